pattern_det_ctrl: RTL and testbench
===================================

// Module: pattern_det_ctrl
// PURPOSE
//   Sequencing controller for serial pattern detection (default pattern 110).
//   - Arms a detection run on start; consumes a valid/ready serial bit stream; counts matches.
//   - Reports each match as a held event with its bit position; ends the run on target count,
//     on window exhaustion (timeout) or on abort.
//   - Sits between a serial bit source and a status/interrupt consumer.
// PARAMETERS
//   PAT_W  3  pattern length in bits (>=2)
//   CNT_W  8  width of match target and match counter
//   WIN_W  8  width of observation window and bit position counter
// PORTS
//   clk          in   1      sole clock, all logic on posedge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      1-cycle pulse: latch cfg_*, begin run (ignored unless IDLE)
//   abort        in   1      end run immediately, any state
//   cfg_pattern  in   PAT_W  pattern; MSB = first bit received
//   cfg_target   in   CNT_W  matches required to finish; 0 = unlimited
//   cfg_window   in   WIN_W  max bits accepted per run; 0 = unlimited
//   in           in   1      serial data bit
//   in_vld       in   1      in is valid
//   in_rdy       out  1      bit accepted when in_vld & in_rdy
//   evt_vld      out  1      match event pending
//   evt_rdy      in   1      consumer accepts event when evt_vld & evt_rdy
//   evt_pos      out  WIN_W  0-based index of the accepted bit that completed the match
//   match_cnt    out  CNT_W  matches in current/last run
//   busy         out  1      state != IDLE
//   done         out  1      1-cycle pulse at run completion (not on abort)
//   timeout      out  1      last run ended by window; held until next start
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0; shift reg, fill, bit and match counters 0.
//   - States: IDLE, ARMED, HOLD, DONE.
//   - IDLE: on start -> ARMED. Latch cfg_*; clear shreg, fill, bit_cnt, match_cnt, timeout.
//   - ARMED: in_rdy=1. Each accepted bit:
//     - shreg<={shreg[PAT_W-2:0],in}; fill saturates at PAT_W; bit_cnt increments.
//     - Match when new fill==PAT_W and new shreg==pattern.
//     - Overlapping matches allowed (shreg kept after a match).
//   - Match: next cycle evt_vld=1, evt_pos=bit_cnt of that bit, match_cnt++; state -> HOLD.
//   - HOLD: in_rdy=0; evt_vld, evt_pos held stable until evt_rdy. On handshake: evt_vld=0, then
//     - ->DONE if target!=0 && match_cnt==target;
//     - else ->DONE with timeout=1 if window!=0 && bit_cnt==window;
//     - else ->ARMED.
//   - Window: in ARMED, when window!=0 and bit_cnt reaches window with no match on the last bit
//     -> DONE, timeout=1. A match on the last bit wins: it goes through HOLD first.
//   - DONE: done=1 for exactly 1 cycle -> IDLE. match_cnt and timeout persist until next start.
//   - abort: highest priority after rst.
//     - Next cycle: state=IDLE, evt_vld=0, in_rdy=0, no done pulse.
//     - match_cnt keeps its value.
//   - start while busy is ignored. start and abort in the same cycle: abort wins.
//   - Counter wrap:
//     - window=0: bit_cnt and evt_pos wrap modulo 2^WIN_W.
//     - target=0: match_cnt wraps modulo 2^CNT_W; runs end only by abort.
//   - rst mid-run: identical to the reset values above, whatever the state.
// CONFIGURATION
//   PDC_NO_OVERLAP_EN
//     - defined: a match clears shreg and fill, so detections never share bits.
//     - undefined: overlapping detection, as above.
// TESTING
//   1. pattern=110, target=2, window=0, bits 1,1,0,1,1,0, evt_rdy=1
//      -> evt_pos 2 then 5; match_cnt=2; done pulse; busy=0.
//   2. pattern=101, target=0, bits 1,0,1,0,1
//      -> default build: evt_pos 2 and 4.
//      -> PDC_NO_OVERLAP_EN build: evt_pos 2 only.
//   3. pattern=110, target=1, window=4, bits 0,0,0,0
//      -> done pulse, timeout=1, match_cnt=0, evt_vld never set.
//   4. Match at pos 2, evt_rdy=0 for 3 cycles, in_vld=1
//      -> evt_vld and evt_pos=2 stable; in_rdy=0; bit_cnt unchanged; resumes after handshake.
//   5. abort while in HOLD
//      -> next cycle evt_vld=0, busy=0, no done pulse; following start begins a clean run.
//   6. rst during ARMED with fill=2
//      -> all outputs 0; after start, bits 0,1,1,0 give first event at pos 3
//         (no stale shreg contents).

Source files
------------

// File: rtl/pattern_det_ctrl_if.sv
// Serial bit stream and match event channel of the pattern detection controller.
// slave = detector side, master = bit source / event consumer side.
interface pattern_det_ctrl_if #(
    parameter int unsigned WIN_W = 8
);
    logic             in;
    logic             in_vld;
    logic             in_rdy;
    logic             evt_vld;
    logic             evt_rdy;
    logic [WIN_W-1:0] evt_pos;

    modport slave (
        input  in, in_vld, evt_rdy,
        output in_rdy, evt_vld, evt_pos
    );

    modport master (
        output in, in_vld, evt_rdy,
        input  in_rdy, evt_vld, evt_pos
    );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Serial pattern detection run controller: arms on start, counts matches, ends on target/window/abort.
// Optional macro PDC_NO_OVERLAP_EN: a match clears the shift register so detections never share bits.
module pattern_det_ctrl #(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PAT_W-1:0]     cfg_pattern,
    input  logic [CNT_W-1:0]     cfg_target,
    input  logic [WIN_W-1:0]     cfg_window,
    pattern_det_ctrl_if.slave    bus,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {IDLE, ARMED, HOLD, DONE} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [PAT_W-1:0]   shreg_q, shreg_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [WIN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]   evt_pos_q, evt_pos_d;
    logic               evt_vld_q, evt_vld_d;
    logic               in_rdy_q, in_rdy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;

    logic [PAT_W-1:0]   shreg_nxt;
    logic [FILL_W-1:0]  fill_nxt;
    logic [WIN_W-1:0]   bit_nxt;
    logic               hit;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        tgt_d       = tgt_q;
        win_d       = win_q;
        shreg_d     = shreg_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;
        evt_pos_d   = evt_pos_q;
        evt_vld_d   = evt_vld_q;
        timeout_d   = timeout_q;

        shreg_nxt = {shreg_q[PAT_W-2:0], bus.in};
        fill_nxt  = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
        bit_nxt   = bit_cnt_q + WIN_W'(1);
        hit       = (fill_nxt == FILL_W'(PAT_W)) && (shreg_nxt == pat_q);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pat_d       = cfg_pattern;
                    tgt_d       = cfg_target;
                    win_d       = cfg_window;
                    shreg_d     = '0;
                    fill_d      = '0;
                    bit_cnt_d   = '0;
                    match_cnt_d = '0;
                    timeout_d   = 1'b0;
                    state_d     = ARMED;
                end
            end
            ARMED: begin
                if (bus.in_vld && in_rdy_q) begin
                    shreg_d   = shreg_nxt;
                    fill_d    = fill_nxt;
                    bit_cnt_d = bit_nxt;
                    // A match on the final window bit wins over the timeout
                    if (hit) begin
                        evt_vld_d   = 1'b1;
                        evt_pos_d   = bit_cnt_q;
                        match_cnt_d = match_cnt_q + CNT_W'(1);
                        state_d     = HOLD;
`ifdef PDC_NO_OVERLAP_EN
                        shreg_d     = '0;
                        fill_d      = '0;
`endif
                    end else if (win_q != '0 && bit_nxt == win_q) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            HOLD: begin
                if (bus.evt_rdy) begin
                    evt_vld_d = 1'b0;
                    if (tgt_q != '0 && match_cnt_q == tgt_q) begin
                        state_d = DONE;
                    end else if (win_q != '0 && bit_cnt_q == win_q) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d   = IDLE;
            evt_vld_d = 1'b0;
        end

        in_rdy_d = (state_d == ARMED);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            tgt_q       <= '0;
            win_q       <= '0;
            shreg_q     <= '0;
            fill_q      <= '0;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            evt_pos_q   <= '0;
            evt_vld_q   <= 1'b0;
            in_rdy_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            tgt_q       <= tgt_d;
            win_q       <= win_d;
            shreg_q     <= shreg_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
            evt_pos_q   <= evt_pos_d;
            evt_vld_q   <= evt_vld_d;
            in_rdy_q    <= in_rdy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.evt_vld = evt_vld_q;
    assign bus.evt_pos = evt_pos_q;
    assign match_cnt   = match_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Scoreboard bench for pattern_det_ctrl: expected event positions are queued as bits are driven
// and popped on each event handshake.
module tb_pattern_det_ctrl;
    localparam int unsigned PAT_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned WIN_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_target;
    logic [WIN_W-1:0] cfg_window;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;
    logic             timeout;

    pattern_det_ctrl_if #(.WIN_W(WIN_W)) bus ();

    pattern_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_target  (cfg_target),
        .cfg_window  (cfg_window),
        .bus         (bus.slave),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int evt_cycles = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Event monitor: handshake happens on the next posedge
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (bus.evt_vld) evt_cycles++;
        if (bus.evt_vld && bus.evt_rdy) begin
            if (exp_q.size() == 0) begin
                check("evt_unexpected_qlen", 32'(exp_q.size()), 32'd1);
            end else begin
                check("evt_pos", 32'(bus.evt_pos), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic start_run(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t,
                             input logic [WIN_W-1:0] w);
        @(negedge clk);
        cfg_pattern = p;
        cfg_target  = t;
        cfg_window  = w;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in     = b;
        bus.in_vld = 1'b1;
        while (!bus.in_rdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("send_bit_timeout", 32'(bus.in_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_evt_vld"},   32'(bus.evt_vld), 32'd0);
        check({tag, "_evt_pos"},   32'(bus.evt_pos), 32'd0);
        check({tag, "_in_rdy"},    32'(bus.in_rdy),  32'd0);
        check({tag, "_match_cnt"}, 32'(match_cnt),   32'd0);
        check({tag, "_busy"},      32'(busy),        32'd0);
        check({tag, "_done"},      32'(done),        32'd0);
        check({tag, "_timeout"},   32'(timeout),     32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_pattern = '0; cfg_target = '0; cfg_window = '0;
        bus.in = 1'b0; bus.in_vld = 1'b0; bus.evt_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // 1: two matches of 110 reach target 2
        d0 = done_cnt;
        start_run(3'b110, 8'd2, 8'd0);
        check("t1_busy_armed", 32'(busy), 32'd1);
        exp_q.push_back(2); exp_q.push_back(5);
        send_bit(1); send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        wait_idle("t1_idle_timeout");
        check("t1_match_cnt", 32'(match_cnt), 32'd2);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_timeout", 32'(timeout), 32'd0);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: overlap behaviour with 101, unlimited target
        d0 = done_cnt;
        start_run(3'b101, 8'd0, 8'd0);
        exp_q.push_back(2);
`ifndef PDC_NO_OVERLAP_EN
        exp_q.push_back(4);
`endif
        send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
        repeat (3) @(negedge clk);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef PDC_NO_OVERLAP_EN
        check("t2_match_cnt", 32'(match_cnt), 32'd1);
`else
        check("t2_match_cnt", 32'(match_cnt), 32'd2);
`endif
        check("t2_busy", 32'(busy), 32'd1);
        start_run(3'b000, 8'd1, 8'd1);
        check("t2_start_ignored_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t2_abort_busy", 32'(busy), 32'd0);
        check("t2_no_done", 32'(done_cnt - d0), 32'd0);

        // 3: window exhaustion without a match
        d0 = done_cnt; e0 = evt_cycles;
        start_run(3'b110, 8'd1, 8'd4);
        send_bit(0); send_bit(0); send_bit(0); send_bit(0);
        wait_idle("t3_idle_timeout");
        check("t3_timeout", 32'(timeout), 32'd1);
        check("t3_match_cnt", 32'(match_cnt), 32'd0);
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t3_no_evt", 32'(evt_cycles - e0), 32'd0);

        // 4: consumer back-pressure holds the event and stalls the stream
        d0 = done_cnt;
        start_run(3'b110, 8'd2, 8'd0);
        check("t4_timeout_cleared", 32'(timeout), 32'd0);
        bus.evt_rdy = 1'b0;
        exp_q.push_back(2);
        send_bit(1); send_bit(1); send_bit(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in = 1'b1;
            bus.in_vld = 1'b1;
            check("t4_hold_evt_vld", 32'(bus.evt_vld), 32'd1);
            check("t4_hold_evt_pos", 32'(bus.evt_pos), 32'd2);
            check("t4_hold_in_rdy", 32'(bus.in_rdy), 32'd0);
        end
        bus.evt_rdy = 1'b1;
        exp_q.push_back(5);
        send_bit(1); send_bit(1); send_bit(0);
        wait_idle("t4_idle_timeout");
        check("t4_match_cnt", 32'(match_cnt), 32'd2);
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: abort in HOLD, then a clean run
        d0 = done_cnt;
        start_run(3'b110, 8'd0, 8'd0);
        bus.evt_rdy = 1'b0;
        send_bit(1); send_bit(1); send_bit(0);
        @(negedge clk);
        check("t5_hold_evt_vld", 32'(bus.evt_vld), 32'd1);
        check("t5_hold_evt_pos", 32'(bus.evt_pos), 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_evt_vld", 32'(bus.evt_vld), 32'd0);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("t5_abort_match_cnt", 32'(match_cnt), 32'd1);
        repeat (2) @(negedge clk);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        bus.evt_rdy = 1'b1;
        // start and abort together: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t5_start_abort_busy", 32'(busy), 32'd0);
        check("t5_start_abort_cnt", 32'(match_cnt), 32'd1);
        d0 = done_cnt;
        start_run(3'b110, 8'd1, 8'd0);
        exp_q.push_back(2);
        send_bit(1); send_bit(1); send_bit(0);
        wait_idle("t5_idle_timeout");
        check("t5_clean_match_cnt", 32'(match_cnt), 32'd1);
        check("t5_clean_done", 32'(done_cnt - d0), 32'd1);

        // 6: reset mid-run discards the partial pattern
        start_run(3'b110, 8'd0, 8'd0);
        send_bit(1); send_bit(1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("t6_rst");
        rst = 1'b0;
        d0 = done_cnt;
        start_run(3'b110, 8'd1, 8'd0);
        exp_q.push_back(3);
        send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        wait_idle("t6_idle_timeout");
        check("t6_match_cnt", 32'(match_cnt), 32'd1);
        check("t6_done", 32'(done_cnt - d0), 32'd1);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
